pwm_ramp_ctrl: RTL and testbench

Soft-start/soft-stop sequencer that drives the six-channel PWM generator's control words (`PWM_ctrol_0..5`), per-channel `enable` and `enable_charging`. It latches target period/duty words and ramps each channel's duty field (bits [7:0]) toward its target at a programmed rate. Period (bits [15:8]) is loaded directly. It also handles orderly shutdown and latched fault shutdown. It sits between the host register block and the PWM generator, in the `stime` domain.

---
 rtl/pwm_ramp_pkg.sv | 31 +++
 rtl/pwm_ramp_ctrl_if.sv | 44 ++++
 rtl/pwm_ramp_lane.sv | 64 ++++++
 rtl/pwm_ramp_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pwm_ramp_pkg.sv
// Shared definitions for the PWM soft-start/soft-stop sequencer:
// state encodings, control-word field positions and small helpers.
package pwm_ramp_pkg;

  localparam int NUM_CH   = 6;
  localparam int PER_MSB  = 15;
  localparam int PER_LSB  = 8;
  localparam int DUTY_MSB = 7;
  localparam int DUTY_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_RAMP   = 3'd2,
    ST_RUN    = 3'd3,
    ST_RAMPDN = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  // Effective duty target: a duty above the period would never be reached.
  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] m;
    if (a < b) begin
      m = a;
    end else begin
      m = b;
    end
    return m;
  endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Host/generator-facing signal bundle of the ramp sequencer. The host side
// (master) drives commands and targets; the sequencer (slave) drives the
// control words and enables towards the PWM generator.
interface pwm_ramp_ctrl_if;
  import pwm_ramp_pkg::*;

  logic              start;
  logic              stop;
  logic              update;
  logic              fault;
  logic              fault_clr;
  logic [NUM_CH-1:0] chan_mask;
  logic [15:0]       target_0;
  logic [15:0]       target_1;
  logic [15:0]       target_2;
  logic [15:0]       target_3;
  logic [15:0]       target_4;
  logic [15:0]       target_5;
  logic [15:0]       PWM_ctrol_0;
  logic [15:0]       PWM_ctrol_1;
  logic [15:0]       PWM_ctrol_2;
  logic [15:0]       PWM_ctrol_3;
  logic [15:0]       PWM_ctrol_4;
  logic [15:0]       PWM_ctrol_5;
  logic [NUM_CH-1:0] enable;
  logic              enable_charging;
  logic [2:0]        state;
  logic              ramp_done;

  modport master (
    output start, stop, update, fault, fault_clr, chan_mask,
           target_0, target_1, target_2, target_3, target_4, target_5,
    input  PWM_ctrol_0, PWM_ctrol_1, PWM_ctrol_2, PWM_ctrol_3, PWM_ctrol_4,
           PWM_ctrol_5, enable, enable_charging, state, ramp_done
  );

  modport slave (
    input  start, stop, update, fault, fault_clr, chan_mask,
           target_0, target_1, target_2, target_3, target_4, target_5,
    output PWM_ctrol_0, PWM_ctrol_1, PWM_ctrol_2, PWM_ctrol_3, PWM_ctrol_4,
           PWM_ctrol_5, enable, enable_charging, state, ramp_done
  );

endinterface

// File: rtl/pwm_ramp_lane.sv
// One duty-ramp lane: holds a channel's duty and moves it by STEP toward
// the effective target, saturating so it never overshoots or wraps.
module pwm_ramp_lane #(
  parameter int STEP = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [7:0] i_h,
  input  logic [7:0] i_leff,
  output logic [7:0] o_duty,
  output logic       o_hit
);

  logic [7:0] r_duty;
  logic [7:0] w_next;
  logic [8:0] w_up9;
  logic [8:0] w_lo9;

  // 9-bit sums so that neither the upward nor the downward step can wrap.
  assign w_up9 = {1'b0, r_duty} + 9'(STEP);
  assign w_lo9 = {1'b0, i_leff} + 9'(STEP);

  // Next duty after one saturating step toward the effective target.
  always_comb begin
    w_next = r_duty;
    if (r_duty < i_leff) begin
      if (w_up9 > {1'b0, i_leff}) begin
        w_next = i_leff;
      end else begin
        w_next = w_up9[7:0];
      end
    end else if (r_duty > i_leff) begin
      if ({1'b0, r_duty} < w_lo9) begin
        w_next = i_leff;
      end else begin
        w_next = r_duty - 8'(STEP);
      end
    end else begin
      w_next = r_duty;
    end
  end

  assign o_hit  = (w_next == i_leff);
  assign o_duty = r_duty;

  // Duty register: clear beats load (clamp to the new period) beats step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_duty <= 8'd0;
    end else if (i_clr) begin
      r_duty <= 8'd0;
    end else if (i_load) begin
      if (r_duty > i_h) begin
        r_duty <= i_h;
      end
    end else if (i_step) begin
      r_duty <= w_next;
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop sequencer for the six-channel PWM generator. Holds
// the state machine, the step prescaler and the arm counter; the per-channel
// duty ramps live in pwm_ramp_lane.
module pwm_ramp_ctrl
  import pwm_ramp_pkg::*;
#(
  parameter int STEP_DIV   = 1000,
  parameter int STEP       = 1,
  parameter int ARM_CYCLES = 16
) (
  input  logic             stime,
  input  logic             rst,
  pwm_ramp_ctrl_if.slave   bus
);

  localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

  state_t                        r_state;
  logic [NUM_CH-1:0][7:0]        r_per;
  logic [NUM_CH-1:0][7:0]        r_l;
  logic [NUM_CH-1:0]             r_enable;
  logic                          r_en_chg;
  logic                          r_ramp_done;
  logic [15:0]                   r_presc;
  logic [ARM_W-1:0]              r_arm_cnt;

  logic [NUM_CH-1:0][15:0]       w_tgt;
  logic [NUM_CH-1:0][7:0]        w_per_new;
  logic [NUM_CH-1:0][7:0]        w_l_new;
  logic [NUM_CH-1:0]             w_valid_new;
  logic [NUM_CH-1:0][7:0]        w_leff;
  logic [NUM_CH-1:0][7:0]        w_duty;
  logic [NUM_CH-1:0]             w_hit;
  logic [NUM_CH-1:0]             w_lane_clr;
  logic                          w_tc;
  logic                          w_all_hit;
  logic                          w_load;
  logic                          w_step;
  logic                          w_clr_all;

  assign w_tgt = {bus.target_5, bus.target_4, bus.target_3,
                  bus.target_2, bus.target_1, bus.target_0};

  assign w_tc      = (r_presc == 16'(STEP_DIV - 1));
  assign w_all_hit = &(w_hit | ~r_enable);

  // Candidate latch values; a channel with zero period is never enabled.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_valid_new[i] = bus.chan_mask[i] & (w_tgt[i][PER_MSB:PER_LSB] != 8'd0);
      w_per_new[i]   = w_valid_new[i] ? w_tgt[i][PER_MSB:PER_LSB] : 8'd0;
      w_l_new[i]     = w_tgt[i][DUTY_MSB:DUTY_LSB];
      w_leff[i]      = (r_state == ST_RAMPDN) ? 8'd0 : min8(r_l[i], r_per[i]);
    end
  end

  // Lane commands decoded from state and the prioritised inputs.
  always_comb begin
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_clr_all = 1'b0;
    if (bus.fault) begin
      w_clr_all = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!bus.stop && bus.start) begin
            w_load = 1'b1;
          end else begin
            w_clr_all = 1'b1;
          end
        end
        ST_ARM: begin
          if (bus.stop) begin
            w_clr_all = 1'b1;
          end else begin
            w_clr_all = 1'b0;
          end
        end
        ST_RAMP: begin
          if (bus.stop) begin
            w_load = 1'b0;
          end else if (bus.update) begin
            w_load = 1'b1;
          end else begin
            w_step = w_tc;
          end
        end
        ST_RUN: begin
          if (!bus.stop && bus.update) begin
            w_load = 1'b1;
          end else begin
            w_load = 1'b0;
          end
        end
        ST_RAMPDN: w_step    = w_tc;
        ST_FAULT:  w_clr_all = 1'b1;
        default:   w_clr_all = 1'b1;
      endcase
    end
    for (int i = 0; i < NUM_CH; i++) begin
      w_lane_clr[i] = w_clr_all | (w_load & ~w_valid_new[i]);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    pwm_ramp_lane #(.STEP(STEP)) u_lane (
      .i_clk  (stime),
      .i_rst  (rst),
      .i_clr  (w_lane_clr[g]),
      .i_load (w_load),
      .i_step (w_step),
      .i_h    (w_tgt[g][PER_MSB:PER_LSB]),
      .i_leff (w_leff[g]),
      .o_duty (w_duty[g]),
      .o_hit  (w_hit[g])
    );
  end

  // Sequencer state machine with registered period, enables and strobes.
  always_ff @(posedge stime) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_per       <= '0;
      r_l         <= '0;
      r_enable    <= '0;
      r_en_chg    <= 1'b0;
      r_ramp_done <= 1'b0;
      r_presc     <= 16'd0;
      r_arm_cnt   <= '0;
    end else begin
      r_ramp_done <= 1'b0;
      if (bus.fault) begin
        r_state  <= ST_FAULT;
        r_per    <= '0;
        r_enable <= '0;
        r_en_chg <= 1'b0;
        r_presc  <= 16'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (!bus.stop && bus.start) begin
              r_state   <= ST_ARM;
              r_per     <= w_per_new;
              r_l       <= w_l_new;
              r_enable  <= w_valid_new;
              r_en_chg  <= 1'b1;
              r_arm_cnt <= '0;
            end else begin
              r_per    <= '0;
              r_enable <= '0;
              r_en_chg <= 1'b0;
            end
          end
          ST_ARM: begin
            if (bus.stop) begin
              r_state  <= ST_IDLE;
              r_per    <= '0;
              r_enable <= '0;
              r_en_chg <= 1'b0;
            end else if (r_arm_cnt == ARM_W'(ARM_CYCLES - 1)) begin
              r_state <= ST_RAMP;
              r_presc <= 16'd0;
            end else begin
              r_arm_cnt <= r_arm_cnt + 1'b1;
            end
          end
          ST_RAMP: begin
            if (bus.stop) begin
              r_state <= ST_RAMPDN;
              r_presc <= 16'd0;
            end else begin
              r_presc <= w_tc ? 16'd0 : r_presc + 16'd1;
              if (bus.update) begin
                r_per    <= w_per_new;
                r_l      <= w_l_new;
                r_enable <= w_valid_new;
              end else if (w_tc && w_all_hit) begin
                r_state     <= ST_RUN;
                r_ramp_done <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (bus.stop) begin
              r_state <= ST_RAMPDN;
              r_presc <= 16'd0;
            end else if (bus.update) begin
              r_state  <= ST_RAMP;
              r_per    <= w_per_new;
              r_l      <= w_l_new;
              r_enable <= w_valid_new;
            end
          end
          ST_RAMPDN: begin
            r_presc <= w_tc ? 16'd0 : r_presc + 16'd1;
            if (w_tc && w_all_hit) begin
              r_state  <= ST_IDLE;
              r_per    <= '0;
              r_enable <= '0;
              r_en_chg <= 1'b0;
            end
          end
          ST_FAULT: begin
            if (bus.fault_clr) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state  <= ST_IDLE;
            r_per    <= '0;
            r_enable <= '0;
            r_en_chg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.PWM_ctrol_0     = {r_per[0], w_duty[0]};
  assign bus.PWM_ctrol_1     = {r_per[1], w_duty[1]};
  assign bus.PWM_ctrol_2     = {r_per[2], w_duty[2]};
  assign bus.PWM_ctrol_3     = {r_per[3], w_duty[3]};
  assign bus.PWM_ctrol_4     = {r_per[4], w_duty[4]};
  assign bus.PWM_ctrol_5     = {r_per[5], w_duty[5]};
  assign bus.enable          = r_enable;
  assign bus.enable_charging = r_en_chg;
  assign bus.state           = r_state;
  assign bus.ramp_done       = r_ramp_done;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl with STEP_DIV=4, STEP=1, ARM_CYCLES=2.
module tb_pwm_ramp_ctrl;

  logic stime = 1'b0;
  logic rst   = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 stime = ~stime;

  pwm_ramp_ctrl_if bus_if ();

  pwm_ramp_ctrl #(.STEP_DIV(4), .STEP(1), .ARM_CYCLES(2)) dut (
    .stime (stime),
    .rst   (rst),
    .bus   (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge stime);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
    int n = 0;
    while (bus_if.state !== exp && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus_if.state), 32'(exp));
  endtask

  task automatic pulse_start();
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_w0"}, 32'(bus_if.PWM_ctrol_0), 32'h0);
    chk({tag, "_w1"}, 32'(bus_if.PWM_ctrol_1), 32'h0);
    chk({tag, "_w2"}, 32'(bus_if.PWM_ctrol_2), 32'h0);
    chk({tag, "_w3"}, 32'(bus_if.PWM_ctrol_3), 32'h0);
    chk({tag, "_w4"}, 32'(bus_if.PWM_ctrol_4), 32'h0);
    chk({tag, "_w5"}, 32'(bus_if.PWM_ctrol_5), 32'h0);
    chk({tag, "_en"}, 32'(bus_if.enable), 32'h0);
    chk({tag, "_chg"}, 32'(bus_if.enable_charging), 32'h0);
    chk({tag, "_rd"}, 32'(bus_if.ramp_done), 32'h0);
    chk({tag, "_st"}, 32'(bus_if.state), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic bad;
    bus_if.start = 1'b0; bus_if.stop = 1'b0; bus_if.update = 1'b0;
    bus_if.fault = 1'b0; bus_if.fault_clr = 1'b0;
    bus_if.chan_mask = 6'b000001;
    bus_if.target_0 = 16'h0A05; bus_if.target_1 = 16'h0000;
    bus_if.target_2 = 16'h0000; bus_if.target_3 = 16'h0000;
    bus_if.target_4 = 16'h0000; bus_if.target_5 = 16'h0000;
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // 1: basic soft-start
    pulse_start();
    chk("t1_w0", 32'(bus_if.PWM_ctrol_0), 32'h0A00);
    chk("t1_en", 32'(bus_if.enable), 32'h01);
    chk("t1_chg", 32'(bus_if.enable_charging), 32'h1);
    chk("t1_arm", 32'(bus_if.state), 32'd1);
    tick();
    chk("t1_arm2", 32'(bus_if.state), 32'd1);
    tick();
    chk("t1_ramp", 32'(bus_if.state), 32'd2);
    for (int k = 1; k <= 5; k++) begin
      repeat (3) tick();
      chk("t1_hold", 32'(bus_if.PWM_ctrol_0), 32'h0A00 + 32'(k - 1));
      chk("t1_rd_lo", 32'(bus_if.ramp_done), 32'h0);
      tick();
      chk("t1_step", 32'(bus_if.PWM_ctrol_0), 32'h0A00 + 32'(k));
    end
    chk("t1_run", 32'(bus_if.state), 32'd3);
    chk("t1_rd", 32'(bus_if.ramp_done), 32'h1);
    tick();
    chk("t1_rd_pulse", 32'(bus_if.ramp_done), 32'h0);
    chk("t1_w0_run", 32'(bus_if.PWM_ctrol_0), 32'h0A05);

    // 3: downward update in RUN
    bus_if.target_0 = 16'h0603;
    bus_if.update = 1'b1;
    tick();
    bus_if.update = 1'b0;
    chk("t3_latch", 32'(bus_if.PWM_ctrol_0), 32'h0605);
    chk("t3_ramp", 32'(bus_if.state), 32'd2);
    repeat (3) tick();
    chk("t3_hold", 32'(bus_if.PWM_ctrol_0), 32'h0605);
    tick();
    chk("t3_d4", 32'(bus_if.PWM_ctrol_0), 32'h0604);
    repeat (4) tick();
    chk("t3_d3", 32'(bus_if.PWM_ctrol_0), 32'h0603);
    chk("t3_run", 32'(bus_if.state), 32'd3);
    chk("t3_rd", 32'(bus_if.ramp_done), 32'h1);

    // 4: soft-stop from duty 5
    bus_if.target_0 = 16'h0A05;
    bus_if.update = 1'b1;
    tick();
    bus_if.update = 1'b0;
    wait_state("t4_run", 3'd3, 40);
    chk("t4_w0", 32'(bus_if.PWM_ctrol_0), 32'h0A05);
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    chk("t4_rampdn", 32'(bus_if.state), 32'd4);
    for (int k = 4; k >= 0; k--) begin
      if (k == 4) bus_if.start = 1'b1;
      tick();
      bus_if.start = 1'b0;
      repeat (3) tick();
      if (k > 0) begin
        chk("t4_st", 32'(bus_if.state), 32'd4);
        chk("t4_down", 32'(bus_if.PWM_ctrol_0), 32'h0A00 + 32'(k));
      end else begin
        chk_all_zero("t4_idle");
      end
    end

    // 2: clamp to period and invalid channel
    bus_if.chan_mask = 6'b000110;
    bus_if.target_1 = 16'h0408;
    bus_if.target_2 = 16'h0020;
    pulse_start();
    chk("t2_en", 32'(bus_if.enable), 32'h02);
    chk("t2_w0", 32'(bus_if.PWM_ctrol_0), 32'h0);
    chk("t2_w1", 32'(bus_if.PWM_ctrol_1), 32'h0400);
    bad = 1'b0;
    for (int n = 0; n < 60 && bus_if.state != 3'd3; n++) begin
      tick();
      if (bus_if.enable[2] !== 1'b0 || bus_if.PWM_ctrol_2 !== 16'h0) bad = 1'b1;
    end
    chk("t2_ch2_quiet", 32'(bad), 32'h0);
    chk("t2_run", 32'(bus_if.state), 32'd3);
    chk("t2_sat", 32'(bus_if.PWM_ctrol_1), 32'h0404);
    bus_if.stop = 1'b1;
    tick();
    bus_if.stop = 1'b0;
    wait_state("t2_idle", 3'd0, 60);
    chk("t2_w1_off", 32'(bus_if.PWM_ctrol_1), 32'h0);

    // 5: fault mid-ramp
    bus_if.chan_mask = 6'b000001;
    bus_if.target_0 = 16'h0A05;
    pulse_start();
    wait_state("t5_ramp", 3'd2, 10);
    repeat (5) tick();
    chk("t5_pre", 32'(bus_if.PWM_ctrol_0), 32'h0A01);
    bus_if.fault = 1'b1;
    tick();
    chk("t5_st", 32'(bus_if.state), 32'd5);
    chk("t5_en", 32'(bus_if.enable), 32'h0);
    chk("t5_chg", 32'(bus_if.enable_charging), 32'h0);
    chk("t5_w0", 32'(bus_if.PWM_ctrol_0), 32'h0);
    bus_if.fault_clr = 1'b1;
    tick();
    bus_if.fault_clr = 1'b0;
    chk("t5_clr_ign", 32'(bus_if.state), 32'd5);
    bus_if.fault = 1'b0;
    tick();
    chk("t5_hold", 32'(bus_if.state), 32'd5);
    bus_if.fault_clr = 1'b1;
    tick();
    bus_if.fault_clr = 1'b0;
    chk_all_zero("t5_idle");

    // 6: reset mid-ramp, then restart from duty 0
    pulse_start();
    wait_state("t6_ramp", 3'd2, 10);
    repeat (6) tick();
    chk("t6_pre", 32'(bus_if.PWM_ctrol_0), 32'h0A01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("t6_rst");
    pulse_start();
    chk("t6_arm", 32'(bus_if.state), 32'd1);
    chk("t6_w0", 32'(bus_if.PWM_ctrol_0), 32'h0A00);
    repeat (2) tick();
    chk("t6_ramp2", 32'(bus_if.state), 32'd2);
    repeat (3) tick();
    chk("t6_hold", 32'(bus_if.PWM_ctrol_0), 32'h0A00);
    tick();
    chk("t6_d1", 32'(bus_if.PWM_ctrol_0), 32'h0A01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
